// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and slicing helpers for the multi-port register file
package rf_pkg;

    localparam int DEF_DW   = 32;
    localparam int DEF_NREG = 32;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Base bit of port 'port' in a flattened bus of 'width'-bit fields.
    function automatic int lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy bits with issue-over-writeback priority
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREG    = DEF_NREG,
    parameter int AW      = clog2(NREG),
    parameter int NRD     = 2,
    parameter int NWR     = 2,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_adr,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_adr,
    input  logic [NRD*AW-1:0] rd_adr,
    input  logic [NRD-1:0]    wr_hit,
    output logic [NREG-1:0]   busy_vec,
    output logic [NRD-1:0]    rd_busy
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Clears are applied before the set so a new producer issued in the
    // same cycle as an older writeback keeps the register pending.
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < NWR; k++) begin
            if (wr_en[k]) begin
                busy_d[wr_adr[lsb(k, AW) +: AW]] = 1'b0;
            end
        end
        if (iss_en && !(ZERO_R0 && (iss_adr == '0))) begin
            busy_d[iss_adr] = 1'b1;
        end
        if (ZERO_R0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_busy[i] = busy_q[rd_adr[lsb(i, AW) +: AW]] & ~wr_hit[i];
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/rf_mp.sv
// rtl/rf_mp.sv - multi-port register file with write-first bypass and busy scoreboard
module rf_mp
    import rf_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int NREG    = DEF_NREG,
    parameter int NRD     = 2,
    parameter int NWR     = 2,
    parameter bit ZERO_R0 = 1'b1,
    parameter int AW      = clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    WrEn,
    input  logic [NWR*AW-1:0] WrAdr,
    input  logic [NWR*DW-1:0] WrDt,
    input  logic [NRD*AW-1:0] RdAdr,
    output logic [NRD*DW-1:0] RdDt,
    input  logic              IssEn,
    input  logic [AW-1:0]     IssAdr,
    output logic [NRD-1:0]    RdBusy,
    output logic [NREG-1:0]   BusyVec
);

    logic [DW-1:0]  rf [NREG];
    logic [NWR-1:0] we_eff;
    logic [NRD-1:0] rd_hit;

    // Writes to the hard-wired zero register are dropped everywhere.
    always_comb begin
        we_eff = '0;
        for (int k = 0; k < NWR; k++) begin
            we_eff[k] = WrEn[k] && !(ZERO_R0 && (WrAdr[lsb(k, AW) +: AW] == '0));
        end
    end

    // Later ports are applied last, so port 1 wins on an address clash.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                rf[r] <= '0;
            end
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (we_eff[k]) begin
                    rf[WrAdr[lsb(k, AW) +: AW]] <= WrDt[lsb(k, DW) +: DW];
                end
            end
        end
    end

    always_comb begin
        RdDt   = '0;
        rd_hit = '0;
        for (int i = 0; i < NRD; i++) begin
            RdDt[lsb(i, DW) +: DW] = rf[RdAdr[lsb(i, AW) +: AW]];
            for (int k = 0; k < NWR; k++) begin
                if (we_eff[k] && (WrAdr[lsb(k, AW) +: AW] == RdAdr[lsb(i, AW) +: AW])) begin
                    RdDt[lsb(i, DW) +: DW] = WrDt[lsb(k, DW) +: DW];
                    rd_hit[i]              = 1'b1;
                end
            end
            if (ZERO_R0 && (RdAdr[lsb(i, AW) +: AW] == '0)) begin
                RdDt[lsb(i, DW) +: DW] = '0;
            end
        end
    end

    rf_scoreboard #(
        .NREG    (NREG),
        .AW      (AW),
        .NRD     (NRD),
        .NWR     (NWR),
        .ZERO_R0 (ZERO_R0)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .iss_en   (IssEn),
        .iss_adr  (IssAdr),
        .wr_en    (we_eff),
        .wr_adr   (WrAdr),
        .rd_adr   (RdAdr),
        .wr_hit   (rd_hit),
        .busy_vec (BusyVec),
        .rd_busy  (RdBusy)
    );

endmodule

// File: tb/tb_rf_mp.sv
// tb/tb_rf_mp.sv - directed self-checking bench for rf_mp
module tb_rf_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  WrEn;
    logic [9:0]  WrAdr;
    logic [63:0] WrDt;
    logic [9:0]  RdAdr;
    logic [63:0] RdDt;
    logic        IssEn;
    logic [4:0]  IssAdr;
    logic [1:0]  RdBusy;
    logic [31:0] BusyVec;

    int checks = 0;
    int errors = 0;

    rf_mp dut (
        .clk     (clk),
        .rst     (rst),
        .WrEn    (WrEn),
        .WrAdr   (WrAdr),
        .WrDt    (WrDt),
        .RdAdr   (RdAdr),
        .RdDt    (RdDt),
        .IssEn   (IssEn),
        .IssAdr  (IssAdr),
        .RdBusy  (RdBusy),
        .BusyVec (BusyVec)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                      input logic [4:0] a1, input logic [31:0] d1);
        WrEn  = en;
        WrAdr = {a1, a0};
        WrDt  = {d1, d0};
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        RdAdr = {a1, a0};
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        RdAdr  = '0;
        IssEn  = 1'b0;
        IssAdr = '0;
        tick();
        rst = 1'b0;
        rd(5'd5, 5'd3);
        chk("reset_rd0", {32'h0, RdDt[31:0]}, 64'h0);
        chk("reset_rd1", {32'h0, RdDt[63:32]}, 64'h0);
        chk("reset_busyvec", {32'h0, BusyVec}, 64'h0);
        chk("reset_rdbusy", {62'h0, RdBusy}, 64'h0);

        // Write x5, then reset with a same-cycle write and issue that must be discarded.
        wr(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
        tick();
        wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        rd(5'd5, 5'd5);
        chk("x5_written", {32'h0, RdDt[31:0]}, 64'hDEADBEEF);
        rst = 1'b1;
        wr(2'b01, 5'd5, 32'h12345678, 5'd0, 32'h0);
        IssEn  = 1'b1;
        IssAdr = 5'd6;
        tick();
        rst   = 1'b0;
        IssEn = 1'b0;
        wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        rd(5'd5, 5'd6);
        chk("x5_after_rst", {32'h0, RdDt[31:0]}, 64'h0);
        chk("busy_after_rst", {32'h0, BusyVec}, 64'h0);

        // Dual write to distinct addresses.
        wr(2'b11, 5'd3, 32'h11111111, 5'd4, 32'h22222222);
        tick();
        wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        rd(5'd3, 5'd4);
        chk("dual_x3", {32'h0, RdDt[31:0]}, 64'h11111111);
        chk("dual_x4", {32'h0, RdDt[63:32]}, 64'h22222222);

        // Dual write to the same address: port 1 wins in bypass and storage.
        wr(2'b11, 5'd7, 32'hAAAA0000, 5'd7, 32'h0000BBBB);
        rd(5'd7, 5'd3);
        chk("same_bypass", {32'h0, RdDt[31:0]}, 64'h0000BBBB);
        chk("same_other_port", {32'h0, RdDt[63:32]}, 64'h11111111);
        tick();
        wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        rd(5'd7, 5'd7);
        chk("same_stored", {32'h0, RdDt[31:0]}, 64'h0000BBBB);

        // Write-first bypass over an older stored value.
        wr(2'b01, 5'd9, 32'h1, 5'd0, 32'h0);
        tick();
        wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        rd(5'd9, 5'd9);
        chk("x9_old", {32'h0, RdDt[31:0]}, 64'h1);
        wr(2'b01, 5'd9, 32'h55, 5'd0, 32'h0);
        rd(5'd9, 5'd9);
        chk("x9_bypass_p0", {32'h0, RdDt[31:0]}, 64'h55);
        chk("x9_bypass_p1", {32'h0, RdDt[63:32]}, 64'h55);
        tick();
        wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        rd(5'd9, 5'd9);
        chk("x9_stored", {32'h0, RdDt[31:0]}, 64'h55);

        // Register zero ignores writes and issue.
        wr(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0);
        rd(5'd0, 5'd0);
        chk("x0_bypass", {32'h0, RdDt[31:0]}, 64'h0);
        tick();
        wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        rd(5'd0, 5'd0);
        chk("x0_stored", {32'h0, RdDt[31:0]}, 64'h0);
        IssEn  = 1'b1;
        IssAdr = 5'd0;
        tick();
        IssEn = 1'b0;
        rd(5'd0, 5'd0);
        chk("x0_never_busy", {32'h0, BusyVec}, 64'h0);
        chk("x0_rdbusy", {62'h0, RdBusy}, 64'h0);

        // Scoreboard set, then a writeback clears it.
        IssEn  = 1'b1;
        IssAdr = 5'd12;
        tick();
        IssEn = 1'b0;
        rd(5'd3, 5'd12);
        chk("x12_busy_vec", {32'h0, BusyVec}, 64'h0000_1000);
        chk("x12_rdbusy", {62'h0, RdBusy}, 64'h2);
        wr(2'b10, 5'd0, 32'h0, 5'd12, 32'h77);
        rd(5'd3, 5'd12);
        chk("x12_wb_rdbusy", {62'h0, RdBusy}, 64'h0);
        chk("x12_wb_bypass", {32'h0, RdDt[63:32]}, 64'h77);
        tick();
        wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        rd(5'd3, 5'd12);
        chk("x12_cleared", {32'h0, BusyVec}, 64'h0);

        // Issue and writeback to x12 in the same cycle: issue wins.
        IssEn  = 1'b1;
        IssAdr = 5'd12;
        wr(2'b01, 5'd12, 32'h99, 5'd0, 32'h0);
        tick();
        IssEn = 1'b0;
        wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        rd(5'd12, 5'd12);
        chk("set_wins_vec", {32'h0, BusyVec}, 64'h0000_1000);
        chk("set_wins_rdbusy", {62'h0, RdBusy}, 64'h3);
        chk("set_wins_data", {32'h0, RdDt[31:0]}, 64'h99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
